step_ramp_gen: RTL and testbench
================================

# step_ramp_gen

Trapezoidal-profile step sequencer feeding the stepper phase driver's `rotate_pulse`, `direction` and `module_enable` inputs. It replaces the free-running fixed-period toggle timer. A host issues a move command of N steps with a direction. The block then emits N step toggles, accelerating linearly in period from `START_PERIOD` to `MIN_PERIOD`, cruising, and decelerating symmetrically. It reports completion with a one-cycle `done` pulse.

## Interface
- `START_PERIOD`, 2700000 — clk cycles per step at start/stop (100 ms at 27 MHz); must be ≥ `MIN_PERIOD`.
- `MIN_PERIOD`, 108000 — cruise clk cycles per step; ≥ 2.
- `ACCEL_STEP`, 27000 — period change per step while ramping.
- `COUNT_W`, 16 — width of step counts.
- `clk` in 1 — single clock.
- `rst_n` in 1 — synchronous, active-low reset.
- `cmd_valid` in 1 — move command offered.
- `cmd_ready` out 1 — high in IDLE.
- `cmd_steps` in COUNT_W — steps to issue.
- `cmd_dir` in 1 — direction for the move.
- `abort` in 1 — request early controlled stop.
- `rotate_pulse` out 1 — toggles once per step.
- `direction` out 1 — latched `cmd_dir`.
- `module_enable` out 1 — driver enable.
- `busy` out 1 — move in progress.
- `done` out 1 — one-cycle completion pulse.
- `steps_done` out COUNT_W — steps issued in current/last move.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL.
- Registers:
  - `period` is `$clog2(START_PERIOD+1)` bits.
  - `tick` counter is the same width.
  - `remaining` and `ramp_cnt` are COUNT_W bits.
- **Accept:** `cmd_valid && cmd_ready`.
  - Latch `direction <= cmd_dir`, `remaining <= cmd_steps`, `period <= START_PERIOD`, `tick <= 0`, `ramp_cnt <= 0`, `steps_done <= 0`.
  - If `cmd_steps == 0`: stay IDLE and pulse `done` next cycle; no toggle.
  - Otherwise enter ACCEL.
- **Step event** (any moving state, `tick == period-1`):
  - Toggle `rotate_pulse`, `tick <= 0`.
  - `remaining` decrements; `steps_done` increments. Call the decremented value `rem'`.
- **Per-step update** after each step event:
  - `rem' == 0`: go to IDLE, `done <= 1`.
  - Else if ACCEL or CRUISE and `rem' <= ramp_cnt`: go to DECEL, `period <= min(period+ACCEL_STEP, START_PERIOD)`, `ramp_cnt <= ramp_cnt-1` (saturating at 0).
  - Else if ACCEL and `period-ACCEL_STEP <= MIN_PERIOD`: `period <= MIN_PERIOD`, `ramp_cnt++`, go to CRUISE.
  - Else if ACCEL: `period -= ACCEL_STEP`, `ramp_cnt++`.
  - Else if CRUISE: no change.
  - DECEL: `period <= min(period+ACCEL_STEP, START_PERIOD)`, `ramp_cnt` decrements (saturating).
- Short moves therefore produce a triangular profile.
- **Abort** (while `busy`): `remaining <= min(remaining, ramp_cnt+1)`, state ← DECEL. `period` and `tick` are unchanged. Abort in IDLE is ignored.
- Abort coinciding with a step event: the step event is applied first, then abort clamps using the updated `remaining`/`ramp_cnt`. If `rem' == 0`, the move finishes normally.
- `cmd_valid` while busy is not accepted; the command stays pending.
- `direction` changes only on accept.
- `busy = (state != IDLE)`.

## Timing
- **Reset values:**
  - `rotate_pulse=0`, `direction=0`, `busy=0`, `done=0`, `steps_done=0`, `module_enable=0`.
  - State is IDLE, so `cmd_ready=1` during and after reset.
  - Reset mid-move aborts instantly with no `done`.
- `cmd_ready` is combinational from state.
- All other outputs are registered.
- The first toggle occurs `START_PERIOD` cycles after the accept edge. Each subsequent toggle follows the previous one by the then-current `period`.
- On the final step edge, in the same cycle:
  - `rotate_pulse` toggles
  - `done=1` for exactly one cycle
  - `busy=0`
  - `cmd_ready=1`
- A new command may be accepted in that same `done` cycle.
- `module_enable` rises with `busy` on the accept edge.

## Configuration
- `STEP_RAMP_HOLD_EN` defined: once the first move is accepted after reset, `module_enable` stays 1 in IDLE (holding torque).
- Without it: `module_enable == busy`; the driver de-energises between moves.

## Test plan
All tests use `START_PERIOD=10`, `MIN_PERIOD=4`, `ACCEL_STEP=2`.
- **Full trapezoid:** `cmd_steps=10`, `cmd_dir=1` → toggle intervals 10,8,6,4,4,4,4,6,8,10; `done` exactly 64 cycles after accept; `steps_done=10`; `direction=1`.
- **Triangle:** `cmd_steps=3` → intervals 10,8,10; `done` 28 cycles after accept.
- **Zero steps:** `cmd_steps=0` → no toggle; `done` 1 cycle after accept; `busy` never high.
- **Abort in cruise:** `cmd_steps=10`, `abort` one cycle after the 4th toggle → intervals 10,8,6,4,4,6,8,10; 8 steps total; `done` pulses; `steps_done=8`.
- **Back-to-back and reset:** second command held on `cmd_valid` during a move → accepted in the `done` cycle, new first toggle 10 cycles later. `rst_n=0` mid-move → all outputs 0 next cycle, no `done`.
- **Macro on:** with `STEP_RAMP_HOLD_EN` defined, `module_enable` stays 1 after `done`. Without it, `module_enable` falls with `busy`.

Source files
------------

// File: rtl/step_ramp_gen.sv
// rtl/step_ramp_gen.sv - trapezoidal step sequencer for the stepper phase driver
//
// Takes a move command (step count + direction) and emits one rotate_pulse
// toggle per step. The step period ramps linearly from START_PERIOD down to
// MIN_PERIOD, cruises, then ramps back up symmetrically; short moves give a
// triangular profile. An abort brings the move to a controlled stop.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   cmd_valid/cmd_ready   move command handshake (ready whenever idle)
//   cmd_steps, cmd_dir    step count and direction of the offered move
//   abort                 request an early ramped stop of the current move
//   rotate_pulse          toggles once per step
//   direction             direction latched at command accept
//   module_enable         driver enable
//   busy                  a move is in progress
//   done                  one-cycle pulse when a move completes
//   steps_done            steps issued in the current/last move
//
// Optional build macro:
//   STEP_RAMP_HOLD_EN     once the first move has been accepted after reset,
//                         module_enable stays high while idle (holding torque)

module step_ramp_gen #(
   parameter int unsigned START_PERIOD = 2700000,
   parameter int unsigned MIN_PERIOD   = 108000,
   parameter int unsigned ACCEL_STEP   = 27000,
   parameter int unsigned COUNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COUNT_W-1:0] cmd_steps,
   input  logic               cmd_dir,
   input  logic               abort,
   output logic               rotate_pulse,
   output logic               direction,
   output logic               module_enable,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] steps_done
);

   localparam int PW = $clog2(START_PERIOD + 1);
   localparam logic [PW-1:0] START_P = PW'(START_PERIOD);
   localparam logic [PW-1:0] MIN_P   = PW'(MIN_PERIOD);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEL  = 2'd1,
      CRUISE = 2'd2,
      DECEL  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [PW-1:0]      period, period_nxt;
   logic [PW-1:0]      tick, tick_nxt;
   logic [COUNT_W-1:0] remaining, remaining_nxt;
   logic [COUNT_W-1:0] ramp_cnt, ramp_nxt;
   logic [COUNT_W-1:0] steps_nxt;
   logic               rot_nxt;
   logic               dir_nxt;
   logic               done_nxt;
   logic               enable_nxt;
   // Zero-step commands complete one cycle after accept without leaving IDLE.
   logic               zero_pend, zero_pend_nxt;
`ifdef STEP_RAMP_HOLD_EN
   logic               hold, hold_nxt;
`endif

   logic               step_evt;
   logic [COUNT_W-1:0] rem_dec;
   logic [COUNT_W-1:0] ramp_dec;
   logic [COUNT_W-1:0] ramp_inc;
   logic [31:0]        per_sum;
   logic [PW-1:0]      period_up;
   logic [PW-1:0]      period_dn;
   logic [COUNT_W:0]   clamp_lim;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   assign step_evt = (tick == period - PW'(1));
   assign rem_dec  = remaining - COUNT_W'(1);
   assign ramp_dec = (ramp_cnt == '0) ? '0 : ramp_cnt - COUNT_W'(1);
   assign ramp_inc = ramp_cnt + COUNT_W'(1);

   // Period arithmetic is done at 32 bits so slowing down past START_PERIOD
   // and speeding up below MIN_PERIOD never wrap inside the narrow register.
   assign per_sum   = 32'(period) + ACCEL_STEP;
   assign period_up = (per_sum >= START_PERIOD) ? START_P : PW'(per_sum);
   assign period_dn = (32'(period) <= MIN_PERIOD + ACCEL_STEP) ? MIN_P
                      : PW'(32'(period) - ACCEL_STEP);

   always_comb begin
      state_nxt     = state;
      period_nxt    = period;
      tick_nxt      = tick;
      remaining_nxt = remaining;
      ramp_nxt      = ramp_cnt;
      steps_nxt     = steps_done;
      rot_nxt       = rotate_pulse;
      dir_nxt       = direction;
      done_nxt      = zero_pend;
      zero_pend_nxt = 1'b0;
      clamp_lim     = '0;
`ifdef STEP_RAMP_HOLD_EN
      hold_nxt      = hold;
`endif

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               dir_nxt       = cmd_dir;
               remaining_nxt = cmd_steps;
               period_nxt    = START_P;
               tick_nxt      = '0;
               ramp_nxt      = '0;
               steps_nxt     = '0;
               if (cmd_steps == '0) begin
                  zero_pend_nxt = 1'b1;
               end else begin
                  state_nxt = ACCEL;
`ifdef STEP_RAMP_HOLD_EN
                  hold_nxt  = 1'b1;
`endif
               end
            end
         end

         default: begin
            if (step_evt) begin
               rot_nxt       = ~rotate_pulse;
               tick_nxt      = '0;
               remaining_nxt = rem_dec;
               steps_nxt     = steps_done + COUNT_W'(1);
               // ramp_cnt counts the speed-up steps taken, so once the steps
               // left no longer exceed it the slow-down must begin.
               if (rem_dec == '0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else if (state != DECEL && rem_dec <= ramp_cnt) begin
                  state_nxt  = DECEL;
                  period_nxt = period_up;
                  ramp_nxt   = ramp_dec;
               end else if (state == ACCEL) begin
                  period_nxt = period_dn;
                  ramp_nxt   = ramp_inc;
                  if (period_dn == MIN_P && 32'(period) <= MIN_PERIOD + ACCEL_STEP) begin
                     state_nxt = CRUISE;
                  end
               end else if (state == DECEL) begin
                  period_nxt = period_up;
                  ramp_nxt   = ramp_dec;
               end
            end else begin
               tick_nxt = tick + PW'(1);
            end

            // Abort acts on the post-step values; a move whose last step
            // lands in the same cycle simply finishes.
            if (abort && state_nxt != IDLE) begin
               clamp_lim = {1'b0, ramp_nxt} + (COUNT_W+1)'(1);
               if ({1'b0, remaining_nxt} > clamp_lim) begin
                  remaining_nxt = clamp_lim[COUNT_W-1:0];
               end
               state_nxt = DECEL;
            end
         end
      endcase

`ifdef STEP_RAMP_HOLD_EN
      enable_nxt = (state_nxt != IDLE) || hold_nxt;
`else
      enable_nxt = (state_nxt != IDLE);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         period        <= START_P;
         tick          <= '0;
         remaining     <= '0;
         ramp_cnt      <= '0;
         steps_done    <= '0;
         rotate_pulse  <= 1'b0;
         direction     <= 1'b0;
         done          <= 1'b0;
         zero_pend     <= 1'b0;
         module_enable <= 1'b0;
`ifdef STEP_RAMP_HOLD_EN
         hold          <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         period        <= period_nxt;
         tick          <= tick_nxt;
         remaining     <= remaining_nxt;
         ramp_cnt      <= ramp_nxt;
         steps_done    <= steps_nxt;
         rotate_pulse  <= rot_nxt;
         direction     <= dir_nxt;
         done          <= done_nxt;
         zero_pend     <= zero_pend_nxt;
         module_enable <= enable_nxt;
`ifdef STEP_RAMP_HOLD_EN
         hold          <= hold_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_step_ramp_gen.sv
// tb/tb_step_ramp_gen.sv - scoreboard bench for step_ramp_gen

module tb_step_ramp_gen;

   localparam int S  = 10;
   localparam int M  = 4;
   localparam int A  = 2;
   localparam int CW = 16;

   localparam int PH_UP   = 0;
   localparam int PH_FLAT = 1;
   localparam int PH_DOWN = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_dir = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] cmd_steps = '0;
   logic          cmd_ready;
   logic          rotate_pulse;
   logic          direction;
   logic          module_enable;
   logic          busy;
   logic          done;
   logic [CW-1:0] steps_done;

   step_ramp_gen #(
      .START_PERIOD(S),
      .MIN_PERIOD  (M),
      .ACCEL_STEP  (A),
      .COUNT_W     (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_steps    (cmd_steps),
      .cmd_dir      (cmd_dir),
      .abort        (abort),
      .rotate_pulse (rotate_pulse),
      .direction    (direction),
      .module_enable(module_enable),
      .busy         (busy),
      .done         (done),
      .steps_done   (steps_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int at;
      int steps;
      bit dir;
   } done_t;

   int    tog_q[$];
   done_t done_q[$];
   bit    busy_map[int];
   int    hold_from = -1;
   int    mdl[$];
   int    last_done_cyc = -1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, exp);
      end
   endtask

   // Step-level profile: cumulative toggle offsets from the accept edge.
   // ak > 0 means abort lands between toggle ak and toggle ak+1.
   task automatic run_model(input int n, input int ak);
      int rem, rc, p, ph, t;
      rem = n; rc = 0; p = S; ph = PH_UP; t = 0;
      mdl.delete();
      while (rem > 0) begin
         t += p;
         mdl.push_back(t);
         rem--;
         if (rem == 0) break;
         if (ph != PH_DOWN && rem <= rc) begin
            ph = PH_DOWN; p = (p + A > S) ? S : p + A; rc = (rc > 0) ? rc - 1 : 0;
         end else if (ph == PH_UP && p - A <= M) begin
            ph = PH_FLAT; p = M; rc++;
         end else if (ph == PH_UP) begin
            p -= A; rc++;
         end else if (ph == PH_DOWN) begin
            p = (p + A > S) ? S : p + A; rc = (rc > 0) ? rc - 1 : 0;
         end
         if (mdl.size() == ak) begin
            if (rem > rc + 1) rem = rc + 1;
            ph = PH_DOWN;
         end
      end
   endtask

   task automatic expect_move(input int acc, input int n, input bit d, input int ak,
                              output int done_at);
      done_t e;
      run_model(n, ak);
      foreach (mdl[i]) tog_q.push_back(acc + mdl[i]);
      done_at = (n == 0) ? acc + 1 : acc + mdl[mdl.size()-1];
      e.at = done_at; e.steps = mdl.size(); e.dir = d;
      done_q.push_back(e);
      if (n > 0) begin
         for (int c = acc; c < done_at; c++) busy_map[c] = 1'b1;
         if (hold_from < 0) hold_from = acc;
      end
   endtask

   task automatic wait_ready(output bit ok);
      int k;
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      ok = cmd_ready;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL ready_timeout: got cmd_ready=0 after %0d cycles, required 1", k);
      end
   endtask

   task automatic issue(input int n, input bit d, input int ak, output int acc);
      int dn, ab_at;
      bit ok;
      acc = -1000;
      wait_ready(ok);
      if (!ok) return;
      cmd_valid = 1'b1;
      cmd_steps = CW'(n);
      cmd_dir   = d;
      acc = cyc + 1;
      expect_move(acc, n, d, ak, dn);
      ab_at = (ak > 0) ? acc + mdl[ak-1] : -1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_steps = CW'($urandom);
      cmd_dir   = 1'($urandom);
      while (cyc <= dn) begin
         abort = (cyc == ab_at);
         @(negedge clk);
      end
      abort = 1'b0;
   endtask

   task automatic issue_b2b(input int na, input bit da, input int nb, input bit db,
                            output int acc_b);
      int acc_a, dn_a, dn_b;
      bit ok;
      acc_b = -1000;
      wait_ready(ok);
      if (!ok) return;
      cmd_valid = 1'b1;
      cmd_steps = CW'(na);
      cmd_dir   = da;
      acc_a = cyc + 1;
      expect_move(acc_a, na, da, 0, dn_a);
      @(negedge clk);
      cmd_steps = CW'(nb);
      cmd_dir   = db;
      acc_b = dn_a + 1;
      expect_move(acc_b, nb, db, 0, dn_b);
      while (cyc < acc_b) @(negedge clk);
      cmd_valid = 1'b0;
      while (cyc <= dn_b) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever the DUT toggles or signals done.
   logic  prev_rot = 1'b0;
   done_t mon_d;
   bit    mon_busy;
   bit    mon_en;
   always begin
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (rotate_pulse !== prev_rot) begin
            if (tog_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_toggle: got toggle at cycle %0d, required none", cyc);
            end else begin
               chk("toggle_cycle", cyc, tog_q.pop_front());
            end
         end
         if (done) begin
            last_done_cyc = cyc;
            if (done_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
               mon_d = done_q.pop_front();
               chk("done_cycle", cyc, mon_d.at);
               chk("done_steps_done", steps_done, mon_d.steps);
               chk("done_direction", direction, mon_d.dir);
            end
         end
         mon_busy = busy_map.exists(cyc) != 0;
`ifdef STEP_RAMP_HOLD_EN
         mon_en = mon_busy || (hold_from >= 0 && cyc >= hold_from);
`else
         mon_en = mon_busy;
`endif
         chk("busy", busy, mon_busy);
         chk("cmd_ready", cmd_ready, !mon_busy);
         chk("module_enable", module_enable, mon_en);
      end
      prev_rot = rotate_pulse;
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rotate_pulse"}, rotate_pulse, 0);
      chk({tag, "_direction"}, direction, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_steps_done"}, steps_done, 0);
      chk({tag, "_module_enable"}, module_enable, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   initial begin
      int acc, n, ak, dn;
      bit d, ok;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full trapezoid
      issue(10, 1'b1, 0, acc);
      chk("trap_done_latency", last_done_cyc - acc, 64);
      chk("trap_steps_done", steps_done, 10);
      chk("trap_direction", direction, 1);

      // Triangle
      issue(3, 1'b0, 0, acc);
      chk("tri_done_latency", last_done_cyc - acc, 28);
      chk("tri_direction", direction, 0);

      // Zero steps
      issue(0, 1'b1, 0, acc);
      chk("zero_done_latency", last_done_cyc - acc, 1);
      chk("zero_steps_done", steps_done, 0);

      // Abort while idle is ignored
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (5) @(negedge clk);

      // Abort one cycle after the 4th toggle
      issue(10, 1'b1, 4, acc);
      chk("abort_done_latency", last_done_cyc - acc, 56);
      chk("abort_steps_done", steps_done, 8);

      // Back-to-back: second command held during the first move
      issue_b2b(5, 1'b0, 4, 1'b1, acc);
      chk("b2b_steps_done", steps_done, 4);
      chk("b2b_direction", direction, 1);

      // Randomized moves, some aborted part-way
      repeat (12) begin
         n  = $urandom_range(0, 12);
         d  = 1'($urandom_range(0, 1));
         ak = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue(n, d, ak, acc);
      end

      // Reset in the middle of a move: no done, outputs cleared
      wait_ready(ok);
      if (ok) begin
         cmd_valid = 1'b1;
         cmd_steps = CW'(10);
         cmd_dir   = 1'b1;
         acc = cyc + 1;
         expect_move(acc, 10, 1'b1, 0, dn);
         @(negedge clk);
         cmd_valid = 1'b0;
         while (cyc < acc + 25) @(negedge clk);
         rst_n = 1'b0;
         tog_q.delete();
         done_q.delete();
         busy_map.delete();
         hold_from = -1;
         @(negedge clk);
         check_reset_outputs("midmove_reset");
         rst_n = 1'b1;
         repeat (60) @(negedge clk);
      end

      // One more move after reset to show the block recovers
      issue(6, 1'b0, 0, acc);
      chk("post_reset_steps_done", steps_done, 6);

      repeat (3) @(negedge clk);
      chk("pending_toggles", tog_q.size(), 0);
      chk("pending_done", done_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion by time limit, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
